// File: rtl/tm1637_key_reader.sv
// tm1637_key_reader: periodic TM1637 key-scan reader (cmd 0x42) with debounce and valid/ready output.
//   aclk, aresetn      : system clock, synchronous active-low reset
//   bus_grant          : display writer idle, a transaction may start
//   bus_busy           : high while this block owns the bus (START..STOP)
//   tm1637_clk         : TM1637 CLK line
//   dio_oe / dio_in    : open-drain DIO drive (1 = pull low) and synchronised pin sample
//   m_axis_*           : confirmed scan byte stream (0xFF = no key)
//   ack_error          : one-cycle pulse when the command is not ACKed
module tm1637_key_reader #(
  parameter int CLK_DIV     = 250,
  parameter int POLL_PERIOD = 500000
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       bus_grant,
  output logic       bus_busy,
  output logic       tm1637_clk,
  output logic       dio_oe,
  input  logic       dio_in,
  output logic       m_axis_valid,
  output logic [7:0] m_axis_data,
  input  logic       m_axis_ready,
  output logic       ack_error
);
  localparam int CW = $clog2(3 * CLK_DIV);
  localparam int PW = POLL_PERIOD > 1 ? $clog2(POLL_PERIOD) : 1;
  localparam logic [CW-1:0] DIV       = CW'(CLK_DIV);
  localparam logic [CW-1:0] MID_LO    = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] MID_HI    = CW'(CLK_DIV + CLK_DIV / 2);
  localparam logic [CW-1:0] START_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PULSE_END = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] DIO_REL   = CW'(2 * CLK_DIV);
  localparam logic [CW-1:0] STOP_END  = CW'(3 * CLK_DIV - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [7:0]    CMD_READ  = 8'h42;

  typedef enum logic [2:0] {IDLE, START, CMD, CMD_ACK, READ, READ_ACK, STOP, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    rx_q, rx_d;
  logic          nack_q, nack_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          pend_q, pend_d;
  logic [7:0]    prev_q, prev_d, last_q, last_d;
  logic [7:0]    data_q, data_d;
  logic          clk_q, clk_d, oe_q, oe_d, busy_q, busy_d, valid_q, valid_d, aerr_q, aerr_d;
  logic          pulse_end, wrap, start, acked, confirm;

  always_comb begin
    pulse_end = cnt_q == PULSE_END;
    wrap      = poll_q == POLL_LAST;
    start     = state_q == IDLE && pend_q && bus_grant;
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    rx_d      = rx_q;
    nack_d    = nack_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = START;
      end
      START: if (cnt_q == START_END) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = CMD;
      end
      CMD: if (pulse_end) begin
        cnt_d = '0;
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = CMD_ACK;
      end
      CMD_ACK: begin
        if (cnt_q == MID_HI) nack_d = dio_in;
        if (pulse_end) begin
          cnt_d   = '0;
          state_d = nack_q ? STOP : READ;
        end
      end
      READ: begin
        // LSB arrives first, so shifting in from the top leaves bit i in rx[i]
        if (cnt_q == MID_HI) rx_d = {dio_in, rx_q[7:1]};
        if (pulse_end) begin
          cnt_d = '0;
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = READ_ACK;
        end
      end
      READ_ACK: if (pulse_end) begin
        cnt_d   = '0;
        state_d = STOP;
      end
      STOP: if (cnt_q == STOP_END) begin
        cnt_d   = '0;
        state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Pin outputs are decoded from the next state so the registered pins line up with the state register
    busy_d = !(state_d inside {IDLE, DONE});
    clk_d  = state_d inside {IDLE, START, DONE} || cnt_d >= DIV;
    oe_d   = state_d inside {IDLE, DONE} ? 1'b0 :
             state_d == START            ? 1'b1 :
             state_d == STOP             ? cnt_d < DIO_REL :
             cnt_d == MID_LO             ? (state_d == CMD ? !CMD_READ[bit_d] : state_d == READ_ACK) :
                                           oe_q;
    aerr_d  = state_q == CMD_ACK && pulse_end && nack_q;
    poll_d  = wrap ? '0 : poll_q + 1'b1;
    pend_d  = wrap | (pend_q & ~start);
    acked   = state_q == DONE && !nack_q;
    confirm = acked && rx_q == prev_q && rx_q != last_q && !valid_q;
    prev_d  = acked ? rx_q : prev_q;
    last_d  = confirm ? rx_q : last_q;
    data_d  = confirm ? rx_q : data_q;
    valid_d = confirm | (valid_q & ~m_axis_ready);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      rx_q    <= 8'hFF;
      nack_q  <= 1'b0;
      poll_q  <= '0;
      pend_q  <= 1'b0;
      prev_q  <= 8'hFF;
      last_q  <= 8'hFF;
      data_q  <= 8'h00;
      clk_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      nack_q  <= nack_d;
      poll_q  <= poll_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
      last_q  <= last_d;
      data_q  <= data_d;
      clk_q   <= clk_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      aerr_q  <= aerr_d;
    end
  end

  assign tm1637_clk   = clk_q;
  assign dio_oe       = oe_q;
  assign bus_busy     = busy_q;
  assign m_axis_valid = valid_q;
  assign m_axis_data  = data_q;
  assign ack_error    = aerr_q;
endmodule

// File: tb/tb_tm1637_key_reader.sv
// tb_tm1637_key_reader: TM1637 slave model plus debounce reference model for tm1637_key_reader.
module tb_tm1637_key_reader;
  localparam int CD = 4;
  localparam int PP = 300;

  logic       aclk = 1'b0, aresetn = 1'b0, bus_grant = 1'b1, dio_in = 1'b1, m_axis_ready = 1'b1;
  logic       bus_busy, tm1637_clk, dio_oe, m_axis_valid, ack_error;
  logic [7:0] m_axis_data;
  int         checks = 0, errors = 0;

  always #5 aclk = ~aclk;

  tm1637_key_reader #(.CLK_DIV(CD), .POLL_PERIOD(PP)) dut (
    .aclk(aclk), .aresetn(aresetn), .bus_grant(bus_grant), .bus_busy(bus_busy),
    .tm1637_clk(tm1637_clk), .dio_oe(dio_oe), .dio_in(dio_in),
    .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_ready(m_axis_ready),
    .ack_error(ack_error)
  );

  // slave model: ACKs on the 9th pulse, then shifts out key LSB first; decodes the host waveform
  logic [7:0] key = 8'hFF;
  logic       nack_mode = 1'b0;
  logic       pull = 1'b0, clk_p = 1'b1, line_p = 1'b1, busy_p = 1'b0, nacked = 1'b0, line = 1'b1;
  logic       start_seen = 1'b0, stop_seen = 1'b0, last_start = 1'b0, last_stop = 1'b0;
  logic [7:0] cmd = 8'h00, last_cmd = 8'h00;
  int         falls = 0, rises = 0, busy_len = 0, txn_done = 0, txn_starts = 0, aerr_total = 0;
  int         last_len = 0, last_rises = 0;
  logic [7:0] got[$];

  always @(negedge aclk) begin
    if (!aresetn) begin
      pull  = 1'b0;
      falls = 0;
      rises = 0;
    end else begin
      if (bus_busy && !busy_p) begin
        busy_len = 0; rises = 0; falls = 0; cmd = 8'h00;
        start_seen = 1'b0; stop_seen = 1'b0; nacked = 1'b0;
        txn_starts++;
      end
      if (!tm1637_clk && clk_p) begin
        falls++;
        if (falls == 9) begin
          nacked = nack_mode;
          pull   = !nack_mode;
        end else if (falls >= 10 && falls <= 17 && !nacked) pull = !key[3'(falls - 10)];
        else pull = 1'b0;
      end
      line = !dio_oe && !pull;
      if (tm1637_clk && !clk_p) begin
        rises++;
        if (rises <= 8) cmd[3'(rises - 1)] = line;
      end
      if (tm1637_clk && clk_p && line_p && !line) start_seen = 1'b1;
      if (tm1637_clk && clk_p && !line_p && line) stop_seen = 1'b1;
      if (bus_busy) busy_len++;
      if (ack_error) aerr_total++;
      if (m_axis_valid && m_axis_ready) got.push_back(m_axis_data);
      if (!bus_busy && busy_p) begin
        last_len = busy_len; last_rises = rises; last_cmd = cmd;
        last_start = start_seen; last_stop = stop_seen;
        txn_done++;
      end
    end
    line   = !dio_oe && !pull;
    dio_in = line;
    clk_p  = tm1637_clk;
    line_p = line;
    busy_p = bus_busy;
  end

  // debounce reference: confirm on two equal ACKed reads differing from the last report, only when the stream is free
  logic [7:0] m_prev = 8'hFF, m_last = 8'hFF, m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] tbl[4] = '{8'hFF, 8'hF7, 8'hEE, 8'hEF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic wait_txn();
    int t0 = txn_done;
    int n = 0;
    while (txn_done == t0 && n < 3 * PP) begin
      tick(1);
      n++;
    end
    chk("txn_seen", 32'(txn_done != t0), 32'd1);
  endtask

  task automatic setup_poll(input logic [7:0] k, input logic nk, input logic rdy);
    key = k;
    nack_mode = nk;
    m_axis_ready = rdy;
    if (rdy) m_valid = 1'b0;
  endtask

  task automatic finish_poll(input logic [7:0] k, input logic nk, input logic rdy, input int a0);
    chk("txn_len", last_len, nk ? 22 * CD : 40 * CD);
    chk("clk_rises", last_rises, nk ? 10 : 19);
    chk("cmd_byte", 32'(last_cmd), 32'h42);
    chk("start_stop", 32'({last_start, last_stop}), 32'd3);
    chk("ack_error", aerr_total - a0, 32'(nk));
    if (!nk) begin
      if (k == m_prev && k != m_last && !m_valid) begin
        exp_q.push_back(k);
        m_last  = k;
        m_data  = k;
        m_valid = !rdy;
      end
      m_prev = k;
    end
    chk("valid", 32'(m_axis_valid), 32'(m_valid));
    if (m_valid) chk("data_held", 32'(m_axis_data), 32'(m_data));
  endtask

  task automatic do_poll(input logic [7:0] k, input logic nk, input logic rdy);
    int a0;
    setup_poll(k, nk, rdy);
    a0 = aerr_total;
    wait_txn();
    tick(3);
    finish_poll(k, nk, rdy, a0);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int n, s0, a0;
    logic [7:0] k;
    logic nk, rdy;
    tick(3);
    chk("rst_clk", 32'(tm1637_clk), 32'd1);
    chk("rst_oe", 32'(dio_oe), 32'd0);
    chk("rst_busy", 32'(bus_busy), 32'd0);
    chk("rst_valid", 32'(m_axis_valid), 32'd0);
    chk("rst_data", 32'(m_axis_data), 32'h00);
    chk("rst_ack_error", 32'(ack_error), 32'd0);
    aresetn = 1'b1;
    n = 0;
    while (!bus_busy && n < 2 * PP) begin
      tick(1);
      n++;
    end
    chk("first_poll", 32'(n >= PP && n <= PP + 1), 32'd1);
    do_poll(8'hFF, 1'b0, 1'b1);
    do_poll(8'hFF, 1'b0, 1'b1);
    check_stream("idle");
    do_poll(8'hF7, 1'b0, 1'b1);
    do_poll(8'hF7, 1'b0, 1'b1);
    do_poll(8'hF7, 1'b0, 1'b1);
    do_poll(8'hFF, 1'b0, 1'b1);
    do_poll(8'hFF, 1'b0, 1'b1);
    check_stream("press_release");
    do_poll(8'hEF, 1'b0, 1'b1);
    do_poll(8'hFF, 1'b0, 1'b1);
    check_stream("glitch");
    do_poll(8'hE7, 1'b0, 1'b1);
    do_poll(8'h7E, 1'b1, 1'b1);
    do_poll(8'hE7, 1'b0, 1'b1);
    check_stream("nack");
    do_poll(8'hF7, 1'b0, 1'b0);
    do_poll(8'hF7, 1'b0, 1'b0);
    do_poll(8'hEE, 1'b0, 1'b0);
    do_poll(8'hEE, 1'b0, 1'b0);
    do_poll(8'hEE, 1'b0, 1'b1);
    check_stream("backpressure");
    for (int i = 0; i < 24; i++) begin
      k   = tbl[$urandom_range(0, 3)];
      nk  = $urandom_range(0, 5) == 0;
      rdy = $urandom_range(0, 2) != 0;
      do_poll(k, nk, rdy);
    end
    do_poll(key, 1'b0, 1'b1);
    check_stream("random");
    bus_grant = 1'b0;
    tick(2);
    if (bus_busy) begin
      a0 = aerr_total;
      wait_txn();
      tick(3);
      finish_poll(key, 1'b0, 1'b1, a0);
    end
    s0 = txn_starts;
    tick(3 * PP + 20);
    chk("nogrant_starts", txn_starts, s0);
    chk("nogrant_busy", 32'(bus_busy), 32'd0);
    chk("nogrant_clk", 32'({tm1637_clk, dio_oe}), 32'd2);
    setup_poll(key, 1'b0, 1'b1);
    a0 = aerr_total;
    bus_grant = 1'b1;
    wait_txn();
    chk("grant_one_txn", txn_starts, s0 + 1);
    tick(3);
    finish_poll(key, 1'b0, 1'b1, a0);
    check_stream("grant");
    setup_poll(8'hF7, 1'b0, 1'b1);
    n = 0;
    while (!(bus_busy && falls >= 12) && n < 3 * PP) begin
      tick(1);
      n++;
    end
    chk("reached_read", 32'(bus_busy && falls >= 12), 32'd1);
    aresetn = 1'b0;
    tick(1);
    chk("abort_clk", 32'(tm1637_clk), 32'd1);
    chk("abort_oe", 32'(dio_oe), 32'd0);
    chk("abort_busy", 32'(bus_busy), 32'd0);
    m_prev = 8'hFF;
    m_last = 8'hFF;
    m_valid = 1'b0;
    tick(2);
    aresetn = 1'b1;
    do_poll(8'hF7, 1'b0, 1'b1);
    do_poll(8'hF7, 1'b0, 1'b1);
    check_stream("post_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tm1637_key_reader.md
# tm1637_key_reader

Key-scan reader for the TM1637 bus, the read-direction counterpart of the display writer. It periodically runs a TM1637 read-key transaction (command 0x42), debounces the returned scan code and presents each confirmed change as one byte on a valid/ready stream. It sits beside the display controller on the same two-wire bus and uses `bus_grant` / `bus_busy` so the two never drive the bus at the same time.

## Interface
- `CLK_DIV`, 250: aclk cycles per TM1637 CLK half-period (250 gives 100 kHz at 50 MHz); must be even and ≥ 4.
- `POLL_PERIOD`, 500000: aclk cycles between poll attempts (10 ms at 50 MHz).
- `aclk` in 1: system clock; the only clock.
- `aresetn` in 1: synchronous, active-low reset.
- `bus_grant` in 1: display writer is idle; a transaction may start.
- `bus_busy` out 1: high from START entry to STOP completion.
- `tm1637_clk` out 1: TM1637 CLK line.
- `dio_oe` out 1: 1 drives DIO low; 0 releases it (open-drain, external pull-up).
- `dio_in` in 1: sampled DIO pin, already synchronised.
- `m_axis_valid` out 1: confirmed key code available.
- `m_axis_data` out 8: raw TM1637 scan byte; 0xFF means no key.
- `m_axis_ready` in 1: consumer accepts the byte.
- `ack_error` out 1: one-cycle pulse when the TM1637 fails to ACK.

## Operation
- Poll timer counts 0..POLL_PERIOD-1 and wraps. On wrap it sets `poll_pending`. If `bus_grant`=1 while in IDLE with `poll_pending` set, the block enters START and clears `poll_pending`. A pending poll waits for the grant indefinitely. Further wraps while pending do not queue extra polls.
- FSM states:
  - IDLE: CLK=1, DIO released.
  - START: DIO low for CLK_DIV cycles, then CLK low.
  - CMD: 8 bits of 0x42, LSB first. DIO changes at mid low phase. CLK high for CLK_DIV cycles.
  - CMD_ACK: DIO released for one clock pulse. Sample `dio_in` at mid high phase; a 1 is a NACK.
  - READ: 8 clock pulses with DIO released. Sample at mid high phase. Bit i goes to data[i] (LSB first).
  - READ_ACK: host drives DIO low for one clock pulse.
  - STOP: CLK low with DIO low for CLK_DIV cycles, CLK high for CLK_DIV cycles, then DIO released for CLK_DIV cycles.
  - DONE: result processing, one cycle, then IDLE.
- NACK in CMD_ACK: pulse `ack_error`, skip READ/READ_ACK and go to STOP. The read result is discarded and the debounce state is unchanged.
- Debounce:
  - `prev_raw` and `last_reported` both reset to 0xFF.
  - In DONE, a code is confirmed if raw == `prev_raw` and raw != `last_reported`.
  - If it is confirmed and `m_axis_valid`=0: load `m_axis_data`=raw, set `m_axis_valid`, and set `last_reported`=raw.
  - If `m_axis_valid`=1: skip reporting this time, because `last_reported` is unchanged. The change is reported on a later poll after acceptance.
  - `prev_raw`=raw is updated on every ACKed read.
- Stream: `m_axis_valid` is held with stable data until the `m_axis_valid` & `m_axis_ready` cycle, then cleared the next cycle.
- Reset mid-transaction: all state returns to IDLE immediately. CLK=1 and DIO are released, with no stop sequence. The TM1637 recovers on the next START.

## Timing
- Reset values: `tm1637_clk`=1, `dio_oe`=0, `bus_busy`=0, `m_axis_valid`=0, `m_axis_data`=0x00, `ack_error`=0. The poll counter is 0 and `poll_pending`=0.
- First poll wrap occurs POLL_PERIOD cycles after reset release.
- One clock pulse lasts 2·CLK_DIV cycles.
- Full ACKed transaction, from START entry to IDLE: CLK_DIV (START) + 18·2·CLK_DIV (CMD+ACK+READ+ACK) + 3·CLK_DIV (STOP) + 1 (DONE) = 40·CLK_DIV+1 cycles. At default settings this is 10001 cycles.
- NACK transaction: 22·CLK_DIV+1 cycles.
- `bus_busy` rises in the cycle START is entered (registered, same edge as the first DIO drive) and falls on DONE entry.
- `m_axis_valid` rises in the cycle after DONE.
- `ack_error` is high for exactly one cycle, on CMD_ACK exit.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset then idle, with a bus model ACKing and returning 0xFF, and grant held: every poll shows the 0x42 LSB-first waveform and the transaction length is 40·CLK_DIV+1. `m_axis_valid` never rises.
- Model returns 0xF7 on two consecutive polls: exactly one stream byte 0xF7 after the second poll. A third 0xF7 poll produces nothing. Then 0xFF twice produces one byte 0xFF.
- Single glitch poll 0xEF between 0xFF polls: no output.
- Model NACKs the command: `ack_error` pulses once, no READ clocks are seen, the next poll proceeds normally, and the debounce state is unaffected.
- Hold `m_axis_ready`=0 while the code changes 0xF7→0xEE (two polls each): data stays 0xF7. After the handshake, 0xEE appears after the next poll.
- `bus_grant`=0 across three poll wraps: no bus activity and `bus_busy`=0. Raise grant: exactly one transaction. Assert `aresetn`=0 mid-READ: the next cycle shows CLK=1, `dio_oe`=0, `bus_busy`=0.
